// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types for the DDR port arbiter: beat address/data, request slot and FSM states.
package ddr_port_arbiter_pkg;

  localparam int DdrAddrW = 32;
  localparam int DdrDataW = 32;

  typedef logic [DdrAddrW-1:0] ddr_address_t;
  typedef logic [DdrDataW-1:0] ddr_data_t;

  typedef struct packed {
    logic         valid;
    logic         is_write;
    ddr_address_t addr;
    ddr_data_t    data;
  } ddr_req_slot_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RD,
    WAIT_WR
  } arb_state_e;

endpackage

// File: rtl/ddr_rr_arbiter.sv
// Combinational round-robin pick: first full slot at or after ptr, wrapping.
module ddr_rr_arbiter #(
  parameter int NumPorts = 2
) (
  input  logic [NumPorts-1:0]         full,
  input  logic [$clog2(NumPorts)-1:0] ptr,
  output logic                        gnt_valid,
  output logic [$clog2(NumPorts)-1:0] gnt_idx
);

  localparam int IdxW = $clog2(NumPorts);

  logic [IdxW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest full slot is the last one written.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      cand = IdxW'((int'(ptr) + i) % NumPorts);
      if (full[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares one single-beat DDR port among NumPorts requesters: one-deep capture per port,
// one transaction outstanding, round-robin grant, response routed back to the issuer.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int NumPorts = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  ddr_address_t [NumPorts-1:0]   req_address_i,
  input  logic [NumPorts-1:0]           req_w_en_i,
  input  ddr_data_t [NumPorts-1:0]      req_w_data_i,
  output logic [NumPorts-1:0]           req_w_done_o,
  input  logic [NumPorts-1:0]           req_r_en_i,
  output ddr_data_t [NumPorts-1:0]      req_r_data_o,
  output logic [NumPorts-1:0]           req_r_valid_o,
  output ddr_address_t                  ddr_address_o,
  output logic                          ddr_w_en_o,
  output ddr_data_t                     ddr_w_data_o,
  input  logic                          ddr_w_done_i,
  output logic                          ddr_r_en_o,
  input  ddr_data_t                     ddr_r_data_i,
  input  logic                          ddr_r_valid_i,
  output logic                          protocol_error_o
);

  localparam int IdxW = $clog2(NumPorts);

  ddr_req_slot_t [NumPorts-1:0] slot_q;
  arb_state_e                   state_q;
  logic [IdxW-1:0]              owner_q;
  logic [IdxW-1:0]              rr_ptr_q;
  logic [IdxW-1:0]              owner_next;
  logic [IdxW-1:0]              gnt_idx;
  logic [NumPorts-1:0]          slot_full;
  logic [NumPorts-1:0]          req_err;
  logic                         gnt_valid;
  logic                         issue;
  logic                         rsp_rd;
  logic                         rsp_wr;
  logic                         rsp_err;
  ddr_req_slot_t                gnt_slot;

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      slot_full[p] = slot_q[p].valid;
      req_err[p]   = (req_r_en_i[p] && req_w_en_i[p]) ||
                     ((req_r_en_i[p] || req_w_en_i[p]) && slot_q[p].valid);
    end
  end

  ddr_rr_arbiter #(.NumPorts(NumPorts)) u_rr (
    .full      (slot_full),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign gnt_slot   = slot_q[gnt_idx];
  assign issue      = (state_q == IDLE) && gnt_valid;
  assign rsp_rd     = (state_q == WAIT_RD) && ddr_r_valid_i;
  assign rsp_wr     = (state_q == WAIT_WR) && ddr_w_done_i;
  assign rsp_err    = (ddr_r_valid_i && (state_q != WAIT_RD)) ||
                      (ddr_w_done_i && (state_q != WAIT_WR));
  assign owner_next = (owner_q == IdxW'(NumPorts - 1)) ? '0 : owner_q + 1'b1;

  // The granted slot frees on its issue cycle, so a re-request in the response cycle is captured.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else begin
      for (int p = 0; p < NumPorts; p++) begin
        if (issue && (gnt_idx == IdxW'(p))) begin
          slot_q[p].valid <= 1'b0;
        end else if (!slot_q[p].valid && (req_r_en_i[p] || req_w_en_i[p])) begin
          slot_q[p] <= '{valid: 1'b1, is_write: req_w_en_i[p],
                         addr: req_address_i[p], data: req_w_data_i[p]};
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      owner_q          <= '0;
      rr_ptr_q         <= '0;
      protocol_error_o <= 1'b0;
    end else begin
      if ((|req_err) || rsp_err) begin
        protocol_error_o <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (issue) begin
            owner_q <= gnt_idx;
            state_q <= gnt_slot.is_write ? WAIT_WR : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (ddr_r_valid_i) begin
            rr_ptr_q <= owner_next;
            state_q  <= IDLE;
          end
        end
        WAIT_WR: begin
          if (ddr_w_done_i) begin
            rr_ptr_q <= owner_next;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // DDR pulses are combinational off the slot so a request reaches DDR the cycle after capture.
  always_comb begin
    ddr_r_en_o    = issue && !gnt_slot.is_write;
    ddr_w_en_o    = issue && gnt_slot.is_write;
    ddr_address_o = issue ? gnt_slot.addr : '0;
    ddr_w_data_o  = (issue && gnt_slot.is_write) ? gnt_slot.data : '0;
  end

  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      req_r_valid_o[p] = rsp_rd && (owner_q == IdxW'(p));
      req_w_done_o[p]  = rsp_wr && (owner_q == IdxW'(p));
      req_r_data_o[p]  = req_r_valid_o[p] ? ddr_r_data_i : '0;
    end
  end

endmodule
